// File: rtl/hood_mode_ctrl.sv
// Range-hood mode sequencer: buttons and 1 Hz tick to mode_state,
// with hurricane window, self-clean cycle and run-time tracking.
module hood_mode_ctrl #(
    parameter int unsigned HURR_S         = 60,
    parameter int unsigned CLEAN_S        = 180,
    parameter int unsigned CLEAN_THRESH_S = 36000,
    parameter int unsigned RT_W           = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick_1hz,
    input  logic            power_btn,
    input  logic            menu_btn,
    input  logic            lvl1_btn,
    input  logic            lvl2_btn,
    input  logic            lvl3_btn,
    input  logic            clean_btn,
    output logic [2:0]      mode_state,
    output logic [7:0]      remaining_s,
    output logic            hurr_avail,
    output logic            need_clean,
    output logic [RT_W-1:0] run_time_s
);

    typedef enum logic [2:0] {
        ST_STANDBY = 3'b000,
        ST_L1      = 3'b001,
        ST_L2      = 3'b010,
        ST_HURR    = 3'b011,
        ST_CLEAN   = 3'b100,
        ST_OFF     = 3'b111
    } state_e;

    localparam logic [7:0]      HURR_LD  = 8'(HURR_S);
    localparam logic [7:0]      CLEAN_LD = 8'(CLEAN_S);
    localparam logic [RT_W-1:0] RT_MAX   = '1;
    localparam logic [63:0]     THRESH   = 64'(CLEAN_THRESH_S);

    state_e          state_q, state_d;
    logic [7:0]      rem_q, rem_d;
    logic            hurr_avail_q, hurr_avail_d;
    logic            early_q, early_d;
    logic            need_clean_q, need_clean_d;
    logic [RT_W-1:0] run_time_q, run_time_d;
    logic            go_hurr;
    logic            fan_on;

    // Next-state: button arbitration, countdown and run-time accounting
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        hurr_avail_d = hurr_avail_q;
        early_d      = early_q;
        need_clean_d = need_clean_q | (64'(run_time_q) >= THRESH);
        run_time_d   = run_time_q;
        go_hurr      = 1'b0;
        fan_on       = (state_q == ST_L1) || (state_q == ST_L2) ||
                       (state_q == ST_HURR);

        // Run-time follows the state held before this edge
        if (tick_1hz && fan_on && (run_time_q != RT_MAX)) begin
            run_time_d = run_time_q + 1'b1;
        end

        unique case (state_q)
            ST_OFF: begin
                if (power_btn) begin
                    state_d      = ST_STANDBY;
                    hurr_avail_d = 1'b1;
                end
            end
            ST_STANDBY: begin
                if (power_btn) begin
                    state_d = ST_OFF;
                end else if (clean_btn) begin
                    state_d = ST_CLEAN;
                    rem_d   = CLEAN_LD;
                end else if (lvl3_btn && hurr_avail_q) begin
                    go_hurr = 1'b1;
                end else if (lvl2_btn) begin
                    state_d = ST_L2;
                end else if (lvl1_btn) begin
                    state_d = ST_L1;
                end
            end
            ST_L1, ST_L2: begin
                if (power_btn) begin
                    state_d = ST_OFF;
                end else if (menu_btn) begin
                    state_d = ST_STANDBY;
                end else if (lvl3_btn && hurr_avail_q) begin
                    go_hurr = 1'b1;
                end else if (lvl2_btn) begin
                    state_d = ST_L2;
                end else if (lvl1_btn) begin
                    state_d = ST_L1;
                end
            end
            ST_HURR: begin
                if (menu_btn) begin
                    early_d = 1'b1;
                end
                if (tick_1hz) begin
                    if (rem_q == 8'd1) begin
                        rem_d   = 8'd0;
                        state_d = (early_q || menu_btn) ? ST_STANDBY : ST_L2;
                    end else if (rem_q > 8'd1) begin
                        rem_d = rem_q - 8'd1;
                    end
                end
            end
            ST_CLEAN: begin
                if (tick_1hz) begin
                    if (rem_q == 8'd1) begin
                        rem_d        = 8'd0;
                        state_d      = ST_STANDBY;
                        run_time_d   = '0;
                        need_clean_d = 1'b0;
                    end else if (rem_q > 8'd1) begin
                        rem_d = rem_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase

        // Hurricane entry ignores a coincident tick for the countdown
        if (go_hurr) begin
            state_d      = ST_HURR;
            rem_d        = HURR_LD;
            hurr_avail_d = 1'b0;
            early_d      = 1'b0;
        end
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_OFF;
            rem_q        <= 8'd0;
            hurr_avail_q <= 1'b1;
            early_q      <= 1'b0;
            need_clean_q <= 1'b0;
            run_time_q   <= '0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            hurr_avail_q <= hurr_avail_d;
            early_q      <= early_d;
            need_clean_q <= need_clean_d;
            run_time_q   <= run_time_d;
        end
    end

    assign mode_state  = state_q;
    assign remaining_s = rem_q;
    assign hurr_avail  = hurr_avail_q;
    assign need_clean  = need_clean_q;
    assign run_time_s  = run_time_q;

endmodule

// File: doc/hood_mode_ctrl.md
# hood_mode_ctrl

Mode sequencer for the range-hood controller. It turns debounced button pulses and a 1 Hz tick into the `mode_state` code used by the fan timing and display blocks. It owns the one-shot hurricane window, the self-clean cycle, the accumulated run-time counter and the clean-reminder flag.

## Interface
Parameters:
- `HURR_S`, default 60: hurricane duration in ticks (1..255).
- `CLEAN_S`, default 180: self-clean duration in ticks (1..255).
- `CLEAN_THRESH_S`, default 36000: run-time in ticks at which `need_clean` asserts.
- `RT_W`, default 20: run-time counter width.

Ports (clock and reset first):
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `tick_1hz` in 1: single-cycle pulse, once per second.
- `power_btn` in 1: single-cycle pulse.
- `menu_btn` in 1: single-cycle pulse.
- `lvl1_btn` in 1: single-cycle pulse.
- `lvl2_btn` in 1: single-cycle pulse.
- `lvl3_btn` in 1: single-cycle pulse.
- `clean_btn` in 1: single-cycle pulse.
- `mode_state` out 3: 000 STANDBY, 001 L1, 010 L2, 011 HURR, 100 CLEAN, 111 OFF.
- `remaining_s` out 8: countdown value in HURR/CLEAN; 0 in all other states.
- `hurr_avail` out 1: hurricane may still be entered in this power session.
- `need_clean` out 1: run-time has reached `CLEAN_THRESH_S`.
- `run_time_s` out RT_W: accumulated fan-on ticks; saturating.

## Operation
Reset values: `mode_state`=111 (OFF), `remaining_s`=0, `hurr_avail`=1, `need_clean`=0, `run_time_s`=0, internal `early_exit`=0.

Same-cycle button priority is power > menu > clean > lvl3 > lvl2 > lvl1. Only the highest-priority button that is legal in the current state acts. Illegal buttons are ignored.

Transitions:
- OFF: power → STANDBY, and sets `hurr_avail`=1. All other buttons are ignored.
- STANDBY: power → OFF; clean → CLEAN; lvl3 → HURR only if `hurr_avail`; lvl2 → L2; lvl1 → L1.
- L1/L2: power → OFF; menu → STANDBY; lvl3 → HURR only if `hurr_avail`; lvl1 → L1; lvl2 → L2 (re-selecting the current level is a no-op).
- HURR:
  - Entry loads `remaining_s`=HURR_S, clears `hurr_avail` and clears `early_exit`.
  - menu sets `early_exit`=1. All other buttons, including power, are ignored.
  - On a tick with `remaining_s`=1: exit to STANDBY if `early_exit` is set, else to L2. `remaining_s` becomes 0.
- CLEAN:
  - Entry loads `remaining_s`=CLEAN_S. All buttons are ignored.
  - On a tick with `remaining_s`=1: go to STANDBY, clear `run_time_s` and `need_clean`, and set `remaining_s`=0.
- Countdown: each tick in HURR/CLEAN with `remaining_s`>1 decrements it by 1.
- Run-time:
  - On each tick while in L1, L2 or HURR, `run_time_s` increments, saturating at 2^RT_W−1.
  - `need_clean` is set when the counter reaches `CLEAN_THRESH_S` (≥ compare, registered). It is sticky until a CLEAN cycle completes or reset.
  - The counter does not change when the unit is powered off.

## Timing
- All outputs are registered. A button pulse on cycle N is reflected in `mode_state` at cycle N+1.
- Button and tick in the same cycle: the transition wins. A newly entered HURR/CLEAN loads its full count and ignores that tick. Run-time still counts that tick if the state *before* the edge was L1/L2/HURR.
- HURR lasts exactly HURR_S ticks from entry. CLEAN lasts exactly CLEAN_S ticks.
- menu on the same cycle as the final HURR tick counts as an early exit: next state is STANDBY.
- `need_clean` asserts one cycle after `run_time_s` reaches the threshold.
- Reset asserted mid-HURR/CLEAN: next cycle all outputs take reset values, and no exit transition occurs.
- `tick_1hz` held high for multiple cycles is out of contract.

## Test plan
- Reset, power, lvl1, lvl2, menu → `mode_state` 111→000→001→010→000, each change one cycle after its pulse; `remaining_s`=0 throughout.
- From L1, lvl3, then 60 ticks with no menu → HURR with `remaining_s`=60 counting down to 1, then `mode_state`=010 and `hurr_avail`=0. A second lvl3 stays in L2.
- From STANDBY, lvl3, then menu at tick 20, then the remaining ticks → `mode_state`=000 after the 60th tick. A power off/on cycle restores `hurr_avail`=1.
- With CLEAN_THRESH_S=5: L1 for 5 ticks → `need_clean`=1 and `run_time_s`=5. Then menu, clean, 180 ticks → STANDBY with `run_time_s`=0 and `need_clean`=0. power during CLEAN is ignored.
- Same-cycle power+lvl2 in STANDBY → OFF. lvl3 and tick in the same cycle from L2 → HURR with `remaining_s`=60 and `run_time_s` +1.
- Reset asserted at `remaining_s`=30 in HURR → `mode_state`=111, `remaining_s`=0, `hurr_avail`=1.
